// File: rtl/syscall_sequencer_pkg.sv
// Shared definitions for the SYSCALL sequencer: service codes understood by
// the host, FSM state codes, and the service-code classifier.
package syscall_sequencer_pkg;

  localparam logic [31:0] SYS_PRINT_INT = 32'd1;
  localparam logic [31:0] SYS_PRINT_STR = 32'd4;
  localparam logic [31:0] SYS_READ_INT  = 32'd5;
  localparam logic [31:0] SYS_EXIT      = 32'd10;
  localparam logic [31:0] SYS_PRINT_CHR = 32'd11;

  typedef enum logic [2:0] {
    SSQ_IDLE     = 3'd0,
    SSQ_DRAIN    = 3'd1,
    SSQ_REQ      = 3'd2,
    SSQ_WAIT_ACK = 3'd3,
    SSQ_RESUME   = 3'd4,
    SSQ_HALT     = 3'd5
  } ssq_state_t;

  // Codes that go out to the host over the req/ack handshake.
  // Exit is handled locally and is deliberately not in this set.
  function automatic logic is_host_service(input logic [31:0] code);
    return (code == SYS_PRINT_INT) || (code == SYS_PRINT_STR) ||
           (code == SYS_READ_INT)  || (code == SYS_PRINT_CHR);
  endfunction

endpackage

// File: rtl/syscall_sequencer.sv
// SYSCALL sequencer. Freezes fetch/decode when a syscall sits in ID, waits
// for the older instructions to retire, samples $v0/$a0 and hands the
// request to the host, then resumes the pipeline or halts it for good.
//
// Ports:
//   clk, rst           clock, async active-high reset
//   id_valid           ID holds a real instruction
//   id_syscall         ID instruction decodes as SYSCALL
//   id_flush           ID instruction squashed this cycle
//   v0_value/a0_value  architectural $v0/$a0
//   svc_ack            host completes the outstanding request
//   stall_if_id        hold PC and IF/ID
//   bubble_id_ex       load a NOP into ID/EX
//   svc_req            service request valid
//   svc_code/svc_arg   latched $v0/$a0, stable while svc_req
//   halted             exit serviced, pipeline frozen
//   bad_syscall        sticky: unsupported code seen
//   svc_count          serviced syscalls, wraps
module syscall_sequencer
  import syscall_sequencer_pkg::*;
#(
  parameter int DRAIN_CYCLES = 3,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic             id_syscall,
  input  logic             id_flush,
  input  logic [31:0]      v0_value,
  input  logic [31:0]      a0_value,
  input  logic             svc_ack,
  output logic             stall_if_id,
  output logic             bubble_id_ex,
  output logic             svc_req,
  output logic [31:0]      svc_code,
  output logic [31:0]      svc_arg,
  output logic             halted,
  output logic             bad_syscall,
  output logic [CNT_W-1:0] svc_count
);

  localparam logic [3:0] DRAIN_LOAD = 4'(DRAIN_CYCLES - 1);

  ssq_state_t state, state_nxt;
  logic [3:0] drain_cnt, drain_nxt;
  logic       detect;
  logic       stall_c, bubble_c, req_c, halt_c;
  logic       latch_c, set_bad_c, inc_c;

  assign detect = id_valid & id_syscall & ~id_flush;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= SSQ_IDLE;
      drain_cnt <= 4'd0;
    end else begin
      state     <= state_nxt;
      drain_cnt <= drain_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    drain_nxt = drain_cnt;
    stall_c   = 1'b0;
    bubble_c  = 1'b0;
    req_c     = 1'b0;
    halt_c    = 1'b0;
    latch_c   = 1'b0;
    set_bad_c = 1'b0;
    inc_c     = 1'b0;
    case (state)
      SSQ_IDLE: begin
        // Same-cycle stall so the instruction behind the syscall never enters ID.
        stall_c  = detect;
        bubble_c = detect;
        if (detect) begin
          drain_nxt = DRAIN_LOAD;
          state_nxt = SSQ_DRAIN;
        end
      end
      SSQ_DRAIN: begin
        stall_c  = 1'b1;
        bubble_c = 1'b1;
        if (id_flush)                state_nxt = SSQ_IDLE;
        else if (drain_cnt == 4'd0)  state_nxt = SSQ_REQ;
        else                         drain_nxt = drain_cnt - 4'd1;
      end
      SSQ_REQ: begin
        // Older writes have retired, so the forwarded $v0/$a0 are final here.
        stall_c  = 1'b1;
        bubble_c = 1'b1;
        latch_c  = 1'b1;
        if (is_host_service(v0_value)) begin
          state_nxt = SSQ_WAIT_ACK;
        end else if (v0_value == SYS_EXIT) begin
          state_nxt = SSQ_HALT;
          inc_c     = 1'b1;
        end else begin
          set_bad_c = 1'b1;
          state_nxt = SSQ_RESUME;
        end
      end
      SSQ_WAIT_ACK: begin
        req_c    = 1'b1;
        stall_c  = 1'b1;
        bubble_c = 1'b1;
        if (svc_ack) begin
          state_nxt = SSQ_RESUME;
          inc_c     = 1'b1;
        end
      end
      SSQ_RESUME: begin
        // Let IF/ID advance while the syscall itself leaves ID as a NOP.
        bubble_c  = 1'b1;
        state_nxt = SSQ_IDLE;
      end
      SSQ_HALT: begin
        halt_c   = 1'b1;
        stall_c  = 1'b1;
        bubble_c = 1'b1;
      end
      default: state_nxt = SSQ_IDLE;
    endcase
  end

  // Gate with rst so a reset drops the controls in the same cycle, even if
  // a syscall is still presented in ID while reset is held.
  assign stall_if_id  = stall_c  & ~rst;
  assign bubble_id_ex = bubble_c & ~rst;
  assign svc_req      = req_c    & ~rst;
  assign halted       = halt_c   & ~rst;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      svc_code    <= 32'd0;
      svc_arg     <= 32'd0;
      bad_syscall <= 1'b0;
      svc_count   <= '0;
    end else begin
      if (latch_c) begin
        svc_code <= v0_value;
        svc_arg  <= a0_value;
      end
      if (set_bad_c) bad_syscall <= 1'b1;
      if (inc_c)     svc_count   <= svc_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_syscall_sequencer.sv
// Randomized scoreboard bench for syscall_sequencer.
module tb_syscall_sequencer;
  localparam int D  = 3;
  localparam int CW = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          id_valid = 1'b0, id_syscall = 1'b0, id_flush = 1'b0;
  logic [31:0]   v0_value = '0, a0_value = '0;
  logic          svc_ack = 1'b0;
  logic          stall_if_id, bubble_id_ex, svc_req, halted, bad_syscall;
  logic [31:0]   svc_code, svc_arg;
  logic [CW-1:0] svc_count;

  syscall_sequencer #(.DRAIN_CYCLES(D), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_syscall(id_syscall),
    .id_flush(id_flush), .v0_value(v0_value), .a0_value(a0_value),
    .svc_ack(svc_ack), .stall_if_id(stall_if_id), .bubble_id_ex(bubble_id_ex),
    .svc_req(svc_req), .svc_code(svc_code), .svc_arg(svc_arg),
    .halted(halted), .bad_syscall(bad_syscall), .svc_count(svc_count));

  always #5 clk = ~clk;

  typedef struct packed { logic [31:0] code; logic [31:0] arg; } req_t;
  req_t exp_q[$];
  int   checks = 0, errors = 0;
  int   exp_count = 0;
  bit   exp_bad = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic bit host_code(input logic [31:0] c);
    return c == 1 || c == 4 || c == 5 || c == 11;
  endfunction

  // Monitor: each new request is matched to the scoreboard, then held fields
  // are compared every cycle the request stays up.
  initial begin
    req_t cur;
    bit   prev = 0, have = 0;
    forever begin
      @(negedge clk);
      if (svc_req) begin
        if (!prev) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_req", 1, 0);
            have = 0;
          end else begin
            cur  = exp_q.pop_front();
            have = 1;
            chk("req_code", svc_code, cur.code);
            chk("req_arg", svc_arg, cur.arg);
          end
        end else if (have) begin
          chk("hold_code", svc_code, cur.code);
          chk("hold_arg", svc_arg, cur.arg);
        end
      end
      prev = svc_req;
    end
  end

  // Presents one syscall in ID and plays the host. Called at a negedge;
  // returns at the negedge after RESUME (or after the first HALT cycle).
  task automatic run_sys(input logic [31:0] code, input logic [31:0] arg, input int delay);
    int stall_n = 0, wait_n = 0, exp_stall;
    bit sup, ex, fin = 0;
    sup = host_code(code);
    ex  = (code == 10);
    if (sup) exp_q.push_back('{code, arg});
    v0_value = code; a0_value = arg;
    id_valid = 1; id_syscall = 1; id_flush = 0;
    for (int cyc = 0; cyc < 400 && !fin; cyc++) begin
      #1;
      if (halted) fin = 1;
      else begin
        if (stall_if_id) stall_n++;
        if (svc_req) begin
          svc_ack = (wait_n == delay);
          wait_n++;
          v0_value = $urandom; a0_value = $urandom;
        end else begin
          svc_ack = ($urandom_range(0, 3) == 0);  // must be ignored here
        end
        if (!stall_if_id) begin
          chk("resume_bubble", bubble_id_ex, 1);
          id_valid = 0; id_syscall = 0;
          fin = 1;
        end
      end
      @(negedge clk);
      svc_ack = 0;
    end
    if (!fin) chk("timeout", 0, 1);
    if (sup || ex) exp_count = (exp_count + 1) % (1 << CW);
    if (!sup && !ex) exp_bad = 1;
    exp_stall = 1 + D + 1 + (sup ? delay + 1 : 0);
    chk("stall_cycles", stall_n, exp_stall);
    chk("wait_cycles", wait_n, sup ? delay + 1 : 0);
    chk("halted", halted, ex);
    chk("svc_count", svc_count, exp_count);
    chk("bad_syscall", bad_syscall, exp_bad);
  endtask

  initial begin
    logic [31:0] codes [5];
    int          k;
    bit          seen;
    codes[0] = 1; codes[1] = 4; codes[2] = 5; codes[3] = 11; codes[4] = 99;

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    chk("rst_stall", stall_if_id, 0); chk("rst_bubble", bubble_id_ex, 0);
    chk("rst_req", svc_req, 0);       chk("rst_halted", halted, 0);
    chk("rst_count", svc_count, 0);   chk("rst_bad", bad_syscall, 0);
    chk("rst_code", svc_code, 0);
    @(negedge clk) rst = 0;
    @(negedge clk);

    run_sys(32'd1, 32'h2A, 0);          // print_int, 6 stall cycles
    run_sys(32'd99, 32'h5, 0);          // unsupported
    run_sys(32'd4, 32'h1234_5678, 20);  // slow host, v0/a0 churn while waiting

    // Flush in the detect cycle: no stall at all
    id_valid = 1; id_syscall = 1; id_flush = 1; v0_value = 1;
    #1 chk("flush_detect_stall", stall_if_id, 0);
    chk("flush_detect_bubble", bubble_id_ex, 0);
    @(negedge clk);
    id_valid = 0; id_syscall = 0; id_flush = 0;
    #1 chk("flush_detect_idle", stall_if_id, 0);

    // Flush in the 2nd DRAIN cycle: abort without a request
    @(negedge clk);
    id_valid = 1; id_syscall = 1; v0_value = 4; a0_value = 9;
    #1 chk("flush_drain_detect", stall_if_id, 1);
    @(negedge clk);
    @(negedge clk);
    id_flush = 1;
    #1 chk("flush_drain_stall", stall_if_id, 1);
    @(negedge clk);
    id_flush = 0; id_valid = 0; id_syscall = 0;
    #1 chk("flush_drain_abort", stall_if_id, 0);
    chk("flush_drain_bubble", bubble_id_ex, 0);
    seen = 0;
    repeat (8) begin @(negedge clk); #1 if (svc_req) seen = 1; end
    chk("flush_drain_noreq", seen, 0);
    chk("flush_drain_count", svc_count, exp_count);
    @(negedge clk);

    // Back-to-back
    run_sys(32'd1, 32'd100, 1);
    run_sys(32'd11, 32'h41, 0);

    // Random mix, enough to wrap the narrow counter
    for (int i = 0; i < 25; i++) begin
      k = $urandom_range(0, 5);
      if (k == 5) run_sys($urandom_range(12, 5000), $urandom, 0);
      else        run_sys(codes[k], $urandom, $urandom_range(0, 4));
    end

    // Reset while waiting for ack
    exp_q.push_back('{32'd5, 32'd7});
    v0_value = 5; a0_value = 7; id_valid = 1; id_syscall = 1;
    seen = 0;
    for (int c = 0; c < 20 && !seen; c++) begin
      #1 if (svc_req) seen = 1;
      else @(negedge clk);
    end
    chk("wait_reached", seen, 1);
    rst = 1;
    #1;
    chk("mid_rst_req", svc_req, 0);   chk("mid_rst_stall", stall_if_id, 0);
    chk("mid_rst_bubble", bubble_id_ex, 0); chk("mid_rst_halted", halted, 0);
    chk("mid_rst_count", svc_count, 0); chk("mid_rst_bad", bad_syscall, 0);
    exp_count = 0; exp_bad = 0;
    id_valid = 0; id_syscall = 0;
    @(negedge clk) rst = 0;
    @(negedge clk);

    // Exit: terminal
    run_sys(32'd10, 32'd0, 0);
    for (int c = 0; c < 100; c++) begin
      svc_ack = $urandom_range(0, 1);
      id_valid = 1; id_syscall = 1; v0_value = 1;
      #1;
      chk("halt_halted", halted, 1);
      chk("halt_stall", stall_if_id, 1);
      chk("halt_req", svc_req, 0);
      @(negedge clk);
    end
    chk("halt_count", svc_count, exp_count);
    svc_ack = 0; id_valid = 0; id_syscall = 0;
    rst = 1;
    #1 chk("final_rst_halted", halted, 0);
    chk("final_rst_count", svc_count, 0);
    chk("queue_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
